cla_pipelined_adder: RTL and testbench

//  Parametrised, pipelined carry-lookahead adder/subtractor for the miniRISC ALU datapath.
//  The WIDTH-bit operation is split into STAGES equal segments.

---
 rtl/cla_pipelined_adder.sv | 201 ++++++++++++++++++++
 tb/tb_cla_pipelined_adder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : cla_pipelined_adder
//  Purpose  : Pipelined carry-lookahead adder/subtractor for the miniRISC ALU.
//             The WIDTH-bit operation is cut into STAGES segments of
//             SEG = WIDTH/STAGES bits. One segment is resolved per clock, and
//             the carry between segments is registered. Each segment is built
//             from 4-bit CLA groups joined by a lookahead carry unit (LCU) per
//             16 bits.
//  Ports    : clk, rst (sync, active high)
//             in_valid/in_ready   - operand handshake (a, b, cin, sub)
//             out_valid/out_ready - result handshake (sum, cout[, ovf, zero])
//  Options  : CLA_PIPE_FLAGS_EN - when defined, adds registered ovf (signed
//             overflow) and zero (sum == 0) outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module cla_pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / 4;          // 4-bit CLA groups per segment
    localparam int NBLK = (NGRP + 3) / 4;   // 16-bit LCU blocks per segment
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || (WIDTH % (4 * STAGES)) != 0) begin : g_bad_cfg
        $error("cla_pipelined_adder: WIDTH must be a multiple of 4*STAGES");
    end

    // Carries into positions 0..3 of a 4-wide lookahead, in flattened
    // sum-of-products form (no ripple): c_i = sum_j g_j*prod(p) + c*prod(p).
    function automatic logic [3:0] carries_in(input logic [2:0] p,
                                              input logic [2:0] g,
                                              input logic       c);
        logic [3:0] cv;
        logic       term;
        cv    = '0;
        cv[0] = c;
        for (int i = 1; i < 4; i++) begin
            term = c;
            for (int k = 0; k < i; k++) term = term & p[k];
            cv[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int k = j + 1; k < i; k++) term = term & p[k];
                cv[i] = cv[i] | term;
            end
        end
        return cv;
    endfunction

    // Group generate of four (bit or group) P/G pairs.
    function automatic logic grp_g(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
               (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // One segment: returns {carry_out, sum}.
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] x,
                                             input logic [SEG-1:0] y,
                                             input logic           ci);
        logic [SEG-1:0]    p, g, s;
        logic [4*NBLK-1:0] gp, gg;
        logic [NGRP-1:0]   gcin;
        logic [NBLK:0]     bc;
        logic [3:0]        cg, cb;
        p    = x ^ y;
        g    = x & y;
        s    = '0;
        // Padding groups propagate, so a partial last block passes its carry.
        gp   = '1;
        gg   = '0;
        gcin = '0;
        for (int gi = 0; gi < NGRP; gi++) begin
            gp[gi] = &p[4*gi +: 4];
            gg[gi] = grp_g(p[4*gi +: 4], g[4*gi +: 4]);
        end
        // LCU per 16-bit block; blocks chain on their block-level G/P.
        bc[0] = ci;
        for (int bi = 0; bi < NBLK; bi++) begin
            cg = carries_in(gp[4*bi +: 3], gg[4*bi +: 3], bc[bi]);
            for (int q = 0; q < 4; q++) begin
                if (4*bi + q < NGRP) gcin[4*bi + q] = cg[q];
            end
            bc[bi+1] = grp_g(gp[4*bi +: 4], gg[4*bi +: 4]) |
                       ((&gp[4*bi +: 4]) & bc[bi]);
        end
        for (int gi = 0; gi < NGRP; gi++) begin
            cb = carries_in(p[4*gi +: 3], g[4*gi +: 3], gcin[gi]);
            s[4*gi +: 4] = p[4*gi +: 4] ^ cb;
        end
        return {bc[NBLK], s};
    endfunction

    // A single advance enable freezes the whole pipe under backpressure.
    logic w_adv;
    assign w_adv    = !out_valid | out_ready;
    assign in_ready = w_adv;

    // Stage k sees the unprocessed upper operand bits (REM wide) and the
    // completed lower sum bits (LO wide). Stages 1.. own their input register.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO  = k * SEG;
        localparam int REM = WIDTH - LO;

        logic             w_v;
        logic [REM-1:0]   w_a;
        logic [REM-1:0]   w_b;
        logic             w_c;
        logic [SEG:0]     w_res;
        logic [LO+SEG-1:0] w_done;

        assign w_res = cla_seg(w_a[SEG-1:0], w_b[SEG-1:0], w_c);

        if (k == 0) begin : g_src
            assign w_v    = in_valid;
            assign w_a    = a;
            assign w_b    = sub ? ~b : b;
            assign w_c    = sub | cin;     // subtract forces carry-in to 1
            assign w_done = w_res[SEG-1:0];
        end else begin : g_src
            logic           r_v;
            logic [REM-1:0] r_a;
            logic [REM-1:0] r_b;
            logic           r_c;
            logic [LO-1:0]  r_s;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                    r_a <= '0;
                    r_b <= '0;
                    r_c <= 1'b0;
                    r_s <= '0;
                end else if (w_adv) begin
                    r_v <= g_stage[k-1].w_v;
                    r_a <= g_stage[k-1].w_a[REM+SEG-1:SEG];
                    r_b <= g_stage[k-1].w_b[REM+SEG-1:SEG];
                    r_c <= g_stage[k-1].w_res[SEG];
                    r_s <= g_stage[k-1].w_done;
                end
            end

            assign w_v    = r_v;
            assign w_a    = r_a;
            assign w_b    = r_b;
            assign w_c    = r_c;
            assign w_done = {w_res[SEG-1:0], r_s};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
        end else if (w_adv) begin
            out_valid <= g_stage[LAST].w_v;
            sum       <= g_stage[LAST].w_done;
            cout      <= g_stage[LAST].w_res[SEG];
        end
    end

`ifdef CLA_PIPE_FLAGS_EN
    // Carry into the MSB recovered from the MSB sum bit and its operands.
    logic w_c_msb;
    assign w_c_msb = g_stage[LAST].w_done[WIDTH-1] ^
                     g_stage[LAST].w_a[SEG-1] ^ g_stage[LAST].w_b[SEG-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else if (w_adv) begin
            ovf  <= w_c_msb ^ g_stage[LAST].w_res[SEG];
            zero <= (g_stage[LAST].w_done == '0);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cla_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla_pipelined_adder
//  Purpose  : Scoreboard bench driving three adders (STAGES = 1, 2, 8) with a
//             shared stimulus stream; each has its own expected-result queue.
//             Honours CLA_PIPE_FLAGS_EN for the ovf/zero outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla_pipelined_adder;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic         out_ready;

    logic         iready [3];
    logic         ovalid [3];
    logic [W-1:0] sum_o  [3];
    logic         cout_o [3];
    logic         ovf_o  [3];
    logic         zero_o [3];

    int   stg [3];
    exp_t sb [3][$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

`ifndef CLA_PIPE_FLAGS_EN
    initial for (int i = 0; i < 3; i++) begin ovf_o[i] = 1'b0; zero_o[i] = 1'b0; end
`endif

    cla_pipelined_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovalid[0]),
        .out_ready(out_ready), .sum(sum_o[0]), .cout(cout_o[0])
`ifdef CLA_PIPE_FLAGS_EN
        , .ovf(ovf_o[0]), .zero(zero_o[0])
`endif
    );

    cla_pipelined_adder #(.WIDTH(W), .STAGES(2)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovalid[1]),
        .out_ready(out_ready), .sum(sum_o[1]), .cout(cout_o[1])
`ifdef CLA_PIPE_FLAGS_EN
        , .ovf(ovf_o[1]), .zero(zero_o[1])
`endif
    );

    cla_pipelined_adder #(.WIDTH(W), .STAGES(8)) u_s8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(iready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovalid[2]),
        .out_ready(out_ready), .sum(sum_o[2]), .cout(cout_o[2])
`ifdef CLA_PIPE_FLAGS_EN
        , .ovf(ovf_o[2]), .zero(zero_o[2])
`endif
    );

    // Reference: plain integer arithmetic on the operation's definition.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb_op);
        exp_t       e;
        logic [W:0] full;
        longint     sr;
        if (sb_op) begin
            full[W-1:0] = x - y;
            full[W]     = (x >= y);
            sr = longint'($signed(x)) - longint'($signed(y));
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        e.s = full[W-1:0];
        e.c = full[W];
`ifdef CLA_PIPE_FLAGS_EN
        e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.z = (full[W-1:0] == '0);
`else
        e.v = 1'b0;
        e.z = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [W-1:0] rand_op();
        case ($urandom % 8)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return W'($urandom);
        endcase
    endfunction

    // One beat per call: inputs change on the falling edge, and the expected
    // result is queued for every adder that will take the beat.
    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic c, input logic s, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        sub       = s;
        out_ready = rdy;
        #1;
        if (v && !rst)
            for (int i = 0; i < 3; i++)
                if (iready[i]) sb[i].push_back(model(x, y, c, s));
    endtask

    // Monitor: samples just before each rising edge.
    exp_t         e_pop, act;
    logic         stalled [3] = '{1'b0, 1'b0, 1'b0};
    logic [W-1:0] prev_s  [3];
    logic         prev_c  [3];

    always begin
        @(negedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            act = {sum_o[i], cout_o[i], ovf_o[i], zero_o[i]};
            if (stalled[i]) begin
                n_checks++;
                if (!(ovalid[i] && sum_o[i] == prev_s[i] && cout_o[i] == prev_c[i])) begin
                    n_fail++;
                    $display("FAIL stall_hold s%0d: valid=%b sum=%h cout=%b, need valid=1 sum=%h cout=%b",
                             stg[i], ovalid[i], sum_o[i], cout_o[i], prev_s[i], prev_c[i]);
                end
            end
            if (!rst && ovalid[i] && !out_ready) begin
                n_checks++;
                if (iready[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL in_ready_stall s%0d: in_ready=%b need 0", stg[i], iready[i]);
                end
            end
            if (!rst && ovalid[i] && out_ready) begin
                n_checks++;
                if (sb[i].size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out s%0d: sum=%h cout=%b with nothing in flight",
                             stg[i], sum_o[i], cout_o[i]);
                end else begin
                    e_pop = sb[i].pop_front();
                    if (act !== e_pop) begin
                        n_fail++;
                        $display("FAIL result s%0d: sum=%h cout=%b ovf=%b zero=%b, need sum=%h cout=%b ovf=%b zero=%b",
                                 stg[i], act.s, act.c, act.v, act.z, e_pop.s, e_pop.c, e_pop.v, e_pop.z);
                    end
                end
            end
            stalled[i] = !rst && ovalid[i] && !out_ready;
            prev_s[i]  = sum_o[i];
            prev_c[i]  = cout_o[i];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int lat [3];
    int budget;

    initial begin
        stg       = '{1, 2, 8};
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ovalid[i] !== 1'b0 || sum_o[i] !== '0 || cout_o[i] !== 1'b0 ||
                ovf_o[i] !== 1'b0 || zero_o[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state s%0d: valid=%b sum=%h cout=%b ovf=%b zero=%b, need all 0",
                         stg[i], ovalid[i], sum_o[i], cout_o[i], ovf_o[i], zero_o[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;

        // Latency: FFFFFFFF + 1 appears STAGES edges after acceptance.
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        lat = '{0, 0, 0};
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) in_valid = 1'b0;
            for (int i = 0; i < 3; i++)
                if (ovalid[i] && lat[i] == 0) lat[i] = c;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lat[i] != stg[i]) begin
                n_fail++;
                $display("FAIL latency s%0d: got %0d cycles, need %0d", stg[i], lat[i], stg[i]);
            end
        end

        // Subtract ignores cin; back-to-back stream; segment carry crossing.
        drive(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 32'd1,  32'd2,  1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'd3,  32'd4,  1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'd10, 32'd20, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 32'h0FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        repeat (12) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Fill under backpressure, then drain.
        for (int k = 0; k < 14; k++)
            drive(1'b1, W'(k * 32'h1111_0001), W'(32'hFFFF_0000 + k), 1'b0, k[0], 1'b0);
        repeat (14) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Reset with operations in flight: nothing stale may emerge.
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) sb[i].delete();
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (ovalid[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_flush s%0d: out_valid=%b need 0", stg[i], ovalid[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with random backpressure.
        for (int k = 0; k < 400; k++)
            drive(($urandom % 10) < 7, rand_op(), rand_op(), 1'($urandom),
                  1'($urandom), ($urandom % 10) < 6);

        // Drain with a bounded budget.
        budget = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && budget < 60) begin
            drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            budget++;
        end
        repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (sb[i].size() != 0) begin
                n_fail++;
                $display("FAIL drain s%0d: %0d results missing, need 0", stg[i], sb[i].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
